// File: rtl/vec_com_pkg.sv
// Shared types and default sizes for vec_com_streamer and its FIFO.
package vec_com_pkg;

    localparam int N_DEF     = 8;
    localparam int R_DEF     = 6;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        SEND   = 2'd2
    } state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/vec_com_streamer_if.sv
// Capture-side and stream-side signals of vec_com_streamer as one bundle.
import vec_com_pkg::*;

interface vec_com_streamer_if #(
    parameter int N = N_DEF,
    parameter int R = R_DEF
);
    logic                  com_valid;
    logic [R-1:0][N-1:0]   com_data;
    logic                  com_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          out_data;
    logic                  out_last;
    logic                  busy;
    logic                  overflow;

    modport master (
        output com_valid, com_data, out_ready,
        input  com_ready, out_valid, out_data, out_last, busy, overflow
    );

    modport slave (
        input  com_valid, com_data, out_ready,
        output com_ready, out_valid, out_data, out_last, busy, overflow
    );
endinterface

// File: rtl/vec_fifo.sv
// Synchronous FIFO with wrap-bit pointers; writes while full and pops while empty are ignored.
import vec_com_pkg::*;

module vec_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = clog2_min1(DEPTH);

    logic [AW:0]               wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // Next-state pointers and storage; full/empty are the pre-update view.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (push && !full) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d                = wptr_q + (AW+1)'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= {(AW+1){1'b0}};
            rptr_q <= {(AW+1){1'b0}};
            mem_q  <= {(DEPTH*W){1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/vec_com_streamer.sv
// Buffers COM-captured lane vectors and serialises them lane 0 first onto a valid/ready stream.
// Define VEC_COM_TAG_EN to prefix every vector with an N-bit sequence-number header word.
import vec_com_pkg::*;

module vec_com_streamer #(
    parameter int N     = N_DEF,
    parameter int R     = R_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    vec_com_streamer_if.slave  bus
);
    localparam int             LW        = clog2_min1(R);
    localparam logic [LW-1:0]  LAST_LANE = LW'(R-1);
`ifdef VEC_COM_TAG_EN
    localparam state_e         FIRST_ST  = HEADER;
`else
    localparam state_e         FIRST_ST  = SEND;
`endif

    typedef logic [R-1:0][N-1:0] lane_vec_t;

    state_e        state_q, state_d;
    logic [LW-1:0] lane_q, lane_d;
    lane_vec_t     shadow_q, shadow_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          overflow_q, overflow_d;
`ifdef VEC_COM_TAG_EN
    logic [N-1:0]  seq_q, seq_d;
`endif

    logic          pop, full, empty, hs;
    lane_vec_t     head;

    vec_fifo #(.W(R*N), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.com_valid),
        .wdata (bus.com_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign hs            = out_valid_q && bus.out_ready;
    assign bus.com_ready = !full;
    assign bus.busy      = !empty || (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.overflow  = overflow_q;

    // Serialiser next state; outputs are precomputed from the next state so they leave flops.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        shadow_d = shadow_q;
        pop      = 1'b0;
`ifdef VEC_COM_TAG_EN
        seq_d    = seq_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shadow_d = head;
                    lane_d   = {LW{1'b0}};
                    state_d  = FIRST_ST;
                end else begin
                    state_d  = IDLE;
                end
            end
`ifdef VEC_COM_TAG_EN
            HEADER: begin
                if (hs) begin
                    state_d = SEND;
                end else begin
                    state_d = HEADER;
                end
            end
`endif
            SEND: begin
                if (hs && (lane_q == LAST_LANE)) begin
`ifdef VEC_COM_TAG_EN
                    seq_d = seq_q + N'(1);
`endif
                    // Reload straight from the FIFO so consecutive vectors have no bubble.
                    if (!empty) begin
                        pop      = 1'b1;
                        shadow_d = head;
                        lane_d   = {LW{1'b0}};
                        state_d  = FIRST_ST;
                    end else begin
                        lane_d   = {LW{1'b0}};
                        state_d  = IDLE;
                    end
                end else if (hs) begin
                    lane_d = lane_q + LW'(1);
                end else begin
                    lane_d = lane_q;
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = {LW{1'b0}};
            end
        endcase

        out_valid_d = (state_d != IDLE);
        out_last_d  = (state_d == SEND) && (lane_d == LAST_LANE);
        if (state_d == SEND) begin
            out_data_d = shadow_d[lane_d];
        end else begin
`ifdef VEC_COM_TAG_EN
            out_data_d = seq_d;
`else
            out_data_d = {N{1'b0}};
`endif
        end
        overflow_d = overflow_q || (bus.com_valid && full);
    end

    // Serialiser state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lane_q      <= {LW{1'b0}};
            shadow_q    <= {(R*N){1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {N{1'b0}};
            overflow_q  <= 1'b0;
`ifdef VEC_COM_TAG_EN
            seq_q       <= {N{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            shadow_q    <= shadow_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
`ifdef VEC_COM_TAG_EN
            seq_q       <= seq_d;
`endif
        end
    end

endmodule

// File: tb/tb_vec_com_streamer.sv
// Randomised bench for vec_com_streamer against a queue-level model of buffered vectors and pending words.
module tb_vec_com_streamer;
    import vec_com_pkg::*;

    localparam int N     = 8;
    localparam int R     = 6;
    localparam int DEPTH = 4;
`ifdef VEC_COM_TAG_EN
    localparam int WPV   = R + 1;
`else
    localparam int WPV   = R;
`endif

    typedef logic [R-1:0][N-1:0] vec_t;

    logic clk = 1'b0;
    logic reset;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    vec_com_streamer_if #(.N(N), .R(R)) bus ();

    vec_com_streamer #(.N(N), .R(R), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: vectors waiting in the buffer, and the words still owed for the vector being sent.
    vec_t         mq[$];
    logic [N-1:0] cur[$];
    logic         m_ovf = 1'b0;
    logic [N-1:0] m_seq = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_next();
        vec_t v;
        v = mq.pop_front();
`ifdef VEC_COM_TAG_EN
        cur.push_back(m_seq);
        m_seq = m_seq + 8'd1;
`endif
        for (int i = 0; i < R; i++) cur.push_back(v[i]);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            cur.delete();
            m_ovf = 1'b0;
            m_seq = '0;
        end else begin
            bit acc;
            bit hs;
            acc = bus.com_valid && (mq.size() < DEPTH);
            hs  = (cur.size() > 0) && bus.out_ready;
            if (cur.size() == 0) begin
                if (mq.size() > 0) load_next();
            end else if (hs) begin
                void'(cur.pop_front());
                if (cur.size() == 0 && mq.size() > 0) load_next();
            end
            if (acc) mq.push_back(bus.com_data);
            if (bus.com_valid && !acc) m_ovf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(cur.size() > 0));
            if (cur.size() > 0) begin
                chk("out_data", 32'(bus.out_data), 32'(cur[0]));
                chk("out_last", 32'(bus.out_last), 32'(cur.size() == 1));
            end else begin
                chk("out_last_idle", 32'(bus.out_last), 32'd0);
            end
            chk("com_ready", 32'(bus.com_ready), 32'(mq.size() < DEPTH));
            chk("busy", 32'(bus.busy), 32'((cur.size() > 0) || (mq.size() > 0)));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    function automatic vec_t rand_vec();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        return r64[R*N-1:0];
    endfunction

    task automatic drain(input string name);
        int n;
        bus.com_valid = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_com_ready", 32'(bus.com_ready), 32'd1);
    endtask

    initial begin
        int exp_w[WPV];
        int run;
        int n;
        int sent;
        vec_t v;

        reset         = 1'b1;
        bus.com_valid = 1'b0;
        bus.com_data  = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("init_out_valid", 32'(bus.out_valid), 32'd0);
        chk("init_overflow", 32'(bus.overflow), 32'd0);
        chk("init_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Single vector, lane0 = 1 .. lane5 = 6.
`ifdef VEC_COM_TAG_EN
        exp_w = '{0, 1, 2, 3, 4, 5, 6};
`else
        exp_w = '{1, 2, 3, 4, 5, 6};
`endif
        bus.com_data  = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        bus.com_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.com_valid = 1'b0;
        chk("single_not_yet", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < WPV; i++) begin
            @(negedge clk);
            chk("single_valid", 32'(bus.out_valid), 32'd1);
            chk("single_data", 32'(bus.out_data), 32'(exp_w[i]));
            chk("single_last", 32'(bus.out_last), 32'(i == WPV - 1));
        end
        @(negedge clk);
        chk("single_busy_drop", 32'(bus.busy), 32'd0);

        // Backpressure with out_ready pattern 1,0,0,1.
        bus.com_data  = rand_vec();
        bus.com_valid = 1'b1;
        @(negedge clk);
        bus.com_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.out_ready = (i % 4 == 0) || (i % 4 == 3);
            @(negedge clk);
        end
        drain("bp_drain");

        // Fill with out_ready low: one vector sits in the serialiser, DEPTH in the buffer.
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.com_data  = rand_vec();
            bus.com_valid = 1'b1;
            @(negedge clk);
        end
        bus.com_valid = 1'b0;
        chk("fill_com_ready", 32'(bus.com_ready), 32'd0);
        chk("fill_overflow", 32'(bus.overflow), 32'd1);
        bus.out_ready = 1'b1;
        n = 0;
        run = 0;
        while (bus.busy && n < 200) begin
            if (bus.out_valid) run++;
            @(negedge clk);
            n++;
        end
        chk("fill_words", 32'(run), 32'((DEPTH + 1) * WPV));
        chk("fill_overflow_sticky", 32'(bus.overflow), 32'd1);

        do_reset();

        // Back-to-back: two captures stream without a bubble.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.com_data  = rand_vec();
            bus.com_valid = 1'b1;
            @(negedge clk);
        end
        bus.com_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        while (bus.out_valid && run < 100) begin
            run++;
            @(negedge clk);
        end
        chk("b2b_run", 32'(run), 32'(2 * WPV));

        // Reset with one vector mid-stream and two queued.
        for (int i = 0; i < 3; i++) begin
            bus.com_data  = rand_vec();
            bus.com_valid = 1'b1;
            @(negedge clk);
        end
        bus.com_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_started", 32'(bus.out_valid), 32'd1);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (4) @(negedge clk);
        chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);

`ifdef VEC_COM_TAG_EN
        // 257 vectors: the header counter wraps back through zero.
        do_reset();
        bus.out_ready = 1'b1;
        sent = 0;
        n = 0;
        while (sent < 257 && n < 4000) begin
            bus.com_valid = bus.com_ready;
            bus.com_data  = rand_vec();
            if (bus.com_ready) sent++;
            @(negedge clk);
            n++;
        end
        drain("wrap_drain");
        chk("wrap_sent", 32'(sent), 32'd257);
        chk("wrap_model_seq", 32'(m_seq), 32'd1);
`else
        sent = 0;
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.com_valid = ($urandom_range(0, 99) < 30);
            bus.com_data  = rand_vec();
            bus.out_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
        end
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
